fcmp_pipe: RTL and testbench



---
 rtl/fcmp_pipe.sv | 114 +++++++++++
 tb/tb_fcmp_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_pipe.sv
// Two-stage binary32 compare (FEQ/FLT/FLE) with valid/ready flow control and a routed tag.
// Denormals and -0 are flushed to +0. Exponent 255 is compared as a plain bit pattern.
module fcmp_pipe #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [31:0]      x,
  input  logic [31:0]      y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             z,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_eq_q, s1_lt_q;
  logic [1:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_z_q, s2_z_d;
  logic [TAG_W-1:0] s2_tag_q;

  logic             s1_load, s2_load;
  logic [31:0]      xn, yn;
  logic             eq_d, lt_d;

  assign xn = (x[30:23] == 8'd0) ? 32'd0 : x;
  assign yn = (y[30:23] == 8'd0) ? 32'd0 : y;

  // Sign-magnitude ordering: a negative pair orders by reversed magnitude.
  always_comb begin
    eq_d = (xn == yn);
    lt_d = 1'b0;
    if (xn[31] != yn[31]) begin
      lt_d = xn[31];
    end else if (!xn[31]) begin
      lt_d = (xn[30:0] < yn[30:0]);
    end else begin
      lt_d = (xn[30:0] > yn[30:0]);
    end
  end

  always_comb begin
    s2_z_d = 1'b0;
    case (s1_op_q)
      OP_FEQ:  s2_z_d = s1_eq_q;
      OP_FLT:  s2_z_d = s1_lt_q;
      OP_FLE:  s2_z_d = s1_lt_q | s1_eq_q;
      default: s2_z_d = 1'b0;
    endcase
  end

  // in_ready depends on out_ready but never on in_valid.
  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign s1_load  = in_valid & in_ready;

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_eq_q    <= 1'b0;
      s1_lt_q    <= 1'b0;
      s1_op_q    <= 2'b00;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        s1_eq_q  <= eq_d;
        s1_lt_q  <= lt_d;
        s1_op_q  <= op;
        s1_tag_q <= in_tag;
      end
      if (s2_load) begin
        s2_z_q   <= s2_z_d;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign z         = s2_z_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed and randomised checks of fcmp_pipe: hand-computed vectors for the
// directed cases plus an in-order scoreboard that watches every handshake.
module tb_fcmp_pipe;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       op = 2'b00;
  logic [31:0]      x = 32'd0;
  logic [31:0]      y = 32'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             z;
  logic [TAG_W-1:0] out_tag;

  fcmp_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_sent   = 0;
  int n_recv   = 0;
  logic [TAG_W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] an, bn;
    logic e, l;
    an = (a[30:23] == 8'd0) ? 32'd0 : a;
    bn = (b[30:23] == 8'd0) ? 32'd0 : b;
    e = (an == bn);
    if (an[31] && !bn[31]) l = 1'b1;
    else if (!an[31] && bn[31]) l = 1'b0;
    else if (!an[31]) l = (an[30:0] < bn[30:0]);
    else l = (an[30:0] > bn[30:0]);
    case (o)
      2'b00:   return e;
      2'b01:   return l;
      2'b10:   return e | l;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard: inputs are stable from posedge+1 to the next edge, so the
  // negedge view tells exactly which transfers the coming edge will perform.
  always @(negedge clk) begin
    logic [TAG_W:0] e;
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_recv++;
        if (exp_q.size() == 0) begin
          check("sb_spurious", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_z", 32'(z), 32'(e[0]));
          check("sb_tag", 32'(out_tag), 32'(e[TAG_W:1]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_tag, model(op, x, y)});
        n_sent++;
      end
    end
  end

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t);
    op = o; x = a; y = b; in_tag = t; in_valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t);
    logic acc;
    acc = 1'b0;
    drive(o, a, b, t);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t, input logic exp_z, input string name);
    int lat;
    out_ready = 1'b1;
    send(o, a, b, t);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check({name, "_lat"}, 32'(lat), 32'(2));
    check({name, "_z"}, 32'(z), 32'(exp_z));
    check({name, "_tag"}, 32'(out_tag), 32'(t));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 32'(exp_q.size()), 32'(0));
  endtask

  logic [1:0]  st_op [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b01};
  logic [31:0] st_x  [8] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                             32'hC0000000, 32'h80000000, 32'h7F800000, 32'h00400000};
  logic [31:0] st_y  [8] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                             32'hC0400000, 32'h00000000, 32'h7F800000, 32'h80000000};
  logic        st_z  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic [1:0]  bp_op [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
  logic [31:0] bp_x  [4] = '{32'hBF800000, 32'h3F800000, 32'h40000000, 32'h00000000};
  logic [31:0] bp_y  [4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000};

  logic rand_on = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt, idx, base;
    logic acc, hz;
    logic [TAG_W-1:0] ht;
    logic [31:0] a, b;

    // Reset with in_valid asserted.
    rstn = 1'b0;
    drive(2'b00, 32'h3F800000, 32'h3F800000, 6'd9);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid_rel", 32'(out_valid), 32'(0));
    check("rst_z", 32'(z), 32'(0));
    check("rst_tag", 32'(out_tag), 32'(0));
    @(posedge clk);
    #1;

    run_one(2'b00, 32'h00000001, 32'h80000002, 6'd5, 1'b1, "feq_flush");
    run_one(2'b00, 32'h3F800000, 32'h3F800001, 6'd6, 1'b0, "feq_ne");
    run_one(2'b01, 32'hBF800000, 32'h3F800000, 6'd7, 1'b1, "flt_m1_p1");
    run_one(2'b01, 32'hC0000000, 32'hBF800000, 6'd8, 1'b1, "flt_m2_m1");
    run_one(2'b01, 32'h3F800000, 32'h3F800000, 6'd9, 1'b0, "flt_eq");
    run_one(2'b10, 32'h3F800000, 32'h3F800000, 6'd10, 1'b1, "fle_eq");
    run_one(2'b01, 32'h80000000, 32'h00000000, 6'd11, 1'b0, "flt_zeros");

    // Streaming: op c accepted at end of cycle c, visible in cycle c+2.
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(st_op[c], st_x[c], st_y[c], TAG_W'(c));
      else in_valid = 1'b0;
      @(negedge clk);
      if (c < 8) check("st_in_ready", 32'(in_ready), 32'(1));
      check("st_out_valid", 32'(out_valid), 32'(c >= 2 && c < 10));
      if (c >= 2 && c < 10) begin
        check("st_tag", 32'(out_tag), 32'(c - 2));
        check("st_z", 32'(z), 32'(st_z[c-2]));
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // Backpressure: only two ops fit while out_ready is low.
    out_ready = 1'b0;
    acc_cnt = 0;
    idx = 0;
    hz = 1'b0;
    ht = '0;
    for (int c = 0; c < 6; c++) begin
      drive(bp_op[idx], bp_x[idx], bp_y[idx], TAG_W'(20 + idx));
      @(negedge clk);
      acc = in_ready;
      if (c == 2) begin
        check("bp_first_valid", 32'(out_valid), 32'(1));
        check("bp_first_tag", 32'(out_tag), 32'(20));
        check("bp_first_z", 32'(z), 32'(1));
        hz = z;
        ht = out_tag;
      end else if (c > 2) begin
        check("bp_hold_z", 32'(z), 32'(hz));
        check("bp_hold_tag", 32'(out_tag), 32'(ht));
        check("bp_in_ready", 32'(in_ready), 32'(0));
      end
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cnt++;
        idx++;
      end
    end
    check("bp_accepted", 32'(acc_cnt), 32'(2));
    out_ready = 1'b1;
    send(bp_op[2], bp_x[2], bp_y[2], TAG_W'(22));
    send(bp_op[3], bp_x[3], bp_y[3], TAG_W'(23));
    drain("bp_drain");

    // Randomised out_ready over 1000 ops.
    base = n_recv;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          a = $urandom;
          b = $urandom;
          case ($urandom_range(0, 3))
            0: b = a;
            1: a[30:23] = 8'd0;
            2: b = {~a[31], a[30:0]};
            default: ;
          endcase
          if ($urandom_range(0, 3) == 0) b[30:23] = a[30:23];
          send(2'($urandom_range(0, 3)), a, b, TAG_W'(i));
        end
        rand_on = 1'b0;
      end
    join
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain("rand_drain");
    check("rand_count", 32'(n_recv - base), 32'(1000));

    // Mid-flight reset: two ops parked in the pipe are discarded.
    out_ready = 1'b0;
    send(2'b00, 32'h3F800000, 32'h3F800000, 6'd40);
    send(2'b00, 32'h3F800000, 32'h3F800000, 6'd41);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("mrst_out_valid", 32'(out_valid), 32'(0));
    check("mrst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mrst_no_result", 32'(out_valid), 32'(0));
      @(posedge clk);
      #1;
    end
    run_one(2'b10, 32'hC0000000, 32'h3F800000, 6'd42, 1'b1, "mrst_new");
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
